attopu_ctrl: RTL
================

Name: attopu_ctrl

Overview:
Parametrised multi-cycle control unit for the attopu core, succeeding the purely combinational instruction decoder. It owns the PC, instruction register, zero flag and retired-instruction counter. It sequences fetch/decode/execute/memory through a state machine with req/ack handshakes to instruction and data memory. It drives register-file and ALU control for the external datapath (register file, ALU, data-memory write path).

Parameters:
DATA_W, 16, instruction and data word width
ADDR_W, 16, PC and data address width; IMM_W <= ADDR_W required
RSEL_W, 2, register select width (2**RSEL_W registers)
RESET_PC, 0, PC value after reset
CNT_W, 32, width of retired-instruction counter
Derived constant, not overridable: IMM_W = DATA_W-3-RSEL_W (11 at defaults)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  DATA_W  fetched instruction
rf_wsel  out  RSEL_W  write-back register (rd)
rf_we  out  1  register write enable
rf_wsrc  out  1  0 = ALU result, 1 = dmem read data
rf_rsel1  out  RSEL_W  read port 1 select (rs1)
rf_rsel2  out  RSEL_W  read port 2 select
rf_rdata1  in  ADDR_W  read port 1 value (register address / branch target)
alu_add  out  1  ALU add enable
alu_zero  in  1  ALU result == 0
dmem_req  out  1  data memory request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  data address
dmem_ack  in  1  data access complete (read data valid)
z_flag  out  1  architectural zero flag
instret  out  CNT_W  retired instruction count

Behaviour:
- Instruction fields (W = DATA_W):
  - op = ir[W-1:W-2]
  - rd = ir[W-3 -: RSEL_W]
  - rs1 = next RSEL_W bits
  - rs2 = next RSEL_W bits (overlaps imm)
  - imm = ir[IMM_W:1]
  - mode = ir[0]
- Opcodes: 00 ADD, 01 LD, 10 ST, 11 BRZ. mode 0 = absolute (LD/ST) or relative (BRZ); mode 1 = register.
- Reset (rst_n low at posedge): state=FETCH, pc=RESET_PC, ir=0, z_flag=0, instret=0. While rst_n is low, imem_req, dmem_req, dmem_we, rf_we and alu_add are forced 0 combinationally. Reset mid-transaction abandons it; no write or retire occurs.
- States: FETCH, DECODE, EXEC, MEM.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Stay until imem_ack; on ack, ir<=imem_rdata and go to DECODE. Zero or more wait cycles allowed.
- DECODE: one cycle, no side effects; rf_rsel1/2 settle for the datapath.
- rf_rsel2 = rs2, except ST absolute, where it is rd (store data source).
- rf_wsel = rd; rf_rsel1 = rs1. Both are always driven from ir.
- EXEC, one cycle, always exits to FETCH except LD/ST, which go to MEM:
  - ADD: alu_add=1, rf_we=1, rf_wsrc=0, z_flag<=alu_zero, pc<=pc+1, instret++.
  - LD/ST: go to MEM; pc unchanged.
  - BRZ with z_flag=1:
    - Relative: pc <= pc + sext(imm), mod 2**ADDR_W. The base is the branch's own address.
    - Register: pc <= rf_rdata1.
  - BRZ with z_flag=0: pc<=pc+1.
  - BRZ always retires (instret++).
- MEM:
  - dmem_req=1 and dmem_we = (op==ST).
  - dmem_addr = zext(imm) for absolute, rf_rdata1 for register.
  - Address and we are held stable until dmem_ack.
  - On the ack cycle: LD asserts rf_we=1, rf_wsrc=1. Both then do pc<=pc+1, instret++, and go to FETCH.
- Outputs not named for a state are 0.
- z_flag is changed only by ADD.
- pc+1 wraps from 2**ADDR_W-1 to 0; instret wraps at 2**CNT_W.
- Minimum CPI with zero-wait acks: ADD/BRZ 3 cycles, LD/ST 4 cycles.

Decomposition:
- attopu_pkg holds:
  - opcode localparams OP_ADD/OP_LD/OP_ST/OP_BRZ
  - MODE_ABS/MODE_REG
  - state encoding S_FETCH/S_DECODE/S_EXEC/S_MEM
  - RF_SRC_ALU/RF_SRC_MEM
- One sub-module, attopu_pc_unit, contains the pc register and next-pc mux (hold, +1, +sext(imm), register). It is parametrised by ADDR_W/IMM_W/RESET_PC.

Test Plan:
- Reset then zero-wait fetch of 0x0600 (ADD r0,r1,r2) with alu_zero=1:
  - imem_addr=0 in cycle 1
  - rf_we=1, rf_wsel=0, alu_add=1 in the EXEC cycle
  - z_flag=1, pc=1, instret=1 afterwards
- LD absolute 0x5014 (rd=1, imm=0x00A):
  - dmem_addr=0x000A, dmem_we=0
  - dmem_ack after 3 wait cycles, so dmem_req is high 4 cycles
  - rf_we=1, rf_wsrc=1 only on the ack cycle
- ST register 0x8F01 with rf_rdata1=0x1234:
  - dmem_addr=0x1234, dmem_we=1, rf_rsel2=3
  - no rf_we
  - pc increments after ack
- BRZ relative 0xCFFE (imm=-1) at pc=5:
  - with z_flag=1: next fetch address 4
  - with z_flag=0: next fetch address 6
  - instret increments in both cases
- Wrap: RESET_PC=0xFFFF, ADD executes, next imem_addr=0x0000.
- Assert rst_n low during MEM of a ST:
  - dmem_req/dmem_we drop the same cycle
  - next cycle pc=RESET_PC, FETCH, instret=0, no write observed

Source files
------------

// File: rtl/attopu_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | attopu_pkg : opcodes, modes, FSM states and pc-select encodings    |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
package attopu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LD  = 2'b01;
   localparam logic [1:0] OP_ST  = 2'b10;
   localparam logic [1:0] OP_BRZ = 2'b11;

   localparam logic MODE_ABS = 1'b0;
   localparam logic MODE_REG = 1'b1;

   localparam logic RF_SRC_ALU = 1'b0;
   localparam logic RF_SRC_MEM = 1'b1;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_MEM    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      PC_HOLD = 2'd0,
      PC_INC  = 2'd1,
      PC_REL  = 2'd2,
      PC_REG  = 2'd3
   } pc_sel_t;

endpackage
`default_nettype wire

// File: rtl/attopu_pc_unit.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | attopu_pc_unit : program counter with hold/+1/+sext(imm)/reg mux   |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module attopu_pc_unit
   import attopu_pkg::*;
#(
   parameter int              ADDR_W   = 16,
   parameter int              IMM_W    = 11,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  pc_sel_t           sel_i,
   input  logic [IMM_W-1:0]  imm_i,
   input  logic [ADDR_W-1:0] reg_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   // Relative targets are based on the branch's own address; sums wrap.
   always_comb begin
      pc_d = pc_q;
      case (sel_i)
         PC_INC:  pc_d = pc_q + ADDR_W'(1);
         PC_REL:  pc_d = pc_q + ADDR_W'($signed(imm_i));
         PC_REG:  pc_d = reg_i;
         default: pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/attopu_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | attopu_ctrl : multi-cycle fetch/decode/exec/mem control unit       |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module attopu_ctrl
   import attopu_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter int                RSEL_W   = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [RSEL_W-1:0] rf_wsel,
   output logic              rf_we,
   output logic              rf_wsrc,
   output logic [RSEL_W-1:0] rf_rsel1,
   output logic [RSEL_W-1:0] rf_rsel2,
   input  logic [ADDR_W-1:0] rf_rdata1,
   output logic              alu_add,
   input  logic              alu_zero,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   input  logic              dmem_ack,
   output logic              z_flag,
   output logic [CNT_W-1:0]  instret
);

   localparam int IMM_W = DATA_W - 3 - RSEL_W;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              z_q, z_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   pc_sel_t           w_pc_sel;
   logic [ADDR_W-1:0] w_pc;

   logic [1:0]        w_op;
   logic [RSEL_W-1:0] w_rd, w_rs1, w_rs2;
   logic [IMM_W-1:0]  w_imm;
   logic              w_mode;

   logic              w_imem_req, w_rf_we, w_rf_wsrc, w_alu_add;
   logic              w_dmem_req, w_dmem_we;
   logic [ADDR_W-1:0] w_imem_addr, w_dmem_addr;

   assign w_op   = ir_q[DATA_W-1 -: 2];
   assign w_rd   = ir_q[DATA_W-3 -: RSEL_W];
   assign w_rs1  = ir_q[DATA_W-3-RSEL_W -: RSEL_W];
   assign w_rs2  = ir_q[DATA_W-3-2*RSEL_W -: RSEL_W];
   assign w_imm  = ir_q[IMM_W:1];
   assign w_mode = ir_q[0];

   attopu_pc_unit #(
      .ADDR_W   (ADDR_W),
      .IMM_W    (IMM_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk   (clk),
      .rst_n (rst_n),
      .sel_i (w_pc_sel),
      .imm_i (w_imm),
      .reg_i (rf_rdata1),
      .pc_o  (w_pc)
   );

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      z_d         = z_q;
      instret_d   = instret_q;
      w_pc_sel    = PC_HOLD;
      w_imem_req  = 1'b0;
      w_imem_addr = '0;
      w_rf_we     = 1'b0;
      w_rf_wsrc   = RF_SRC_ALU;
      w_alu_add   = 1'b0;
      w_dmem_req  = 1'b0;
      w_dmem_we   = 1'b0;
      w_dmem_addr = '0;
      case (state_q)
         S_FETCH: begin
            w_imem_req  = 1'b1;
            w_imem_addr = w_pc;
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (w_op)
               OP_ADD: begin
                  w_alu_add = 1'b1;
                  w_rf_we   = 1'b1;
                  z_d       = alu_zero;
                  w_pc_sel  = PC_INC;
                  instret_d = instret_q + CNT_W'(1);
               end
               OP_LD, OP_ST: begin
                  state_d = S_MEM;
               end
               default: begin
                  instret_d = instret_q + CNT_W'(1);
                  if (z_q) begin
                     w_pc_sel = (w_mode == MODE_REG) ? PC_REG : PC_REL;
                  end else begin
                     w_pc_sel = PC_INC;
                  end
               end
            endcase
         end
         S_MEM: begin
            w_dmem_req  = 1'b1;
            w_dmem_we   = (w_op == OP_ST);
            w_dmem_addr = (w_mode == MODE_REG) ? rf_rdata1 : ADDR_W'(w_imm);
            if (dmem_ack) begin
               if (w_op == OP_LD) begin
                  w_rf_we   = 1'b1;
                  w_rf_wsrc = RF_SRC_MEM;
               end
               w_pc_sel  = PC_INC;
               instret_d = instret_q + CNT_W'(1);
               state_d   = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         z_q       <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         z_q       <= z_d;
         instret_q <= instret_d;
      end
   end

   // Strobes are gated by reset so an abandoned access drops immediately.
   assign imem_req  = rst_n & w_imem_req;
   assign dmem_req  = rst_n & w_dmem_req;
   assign dmem_we   = rst_n & w_dmem_we;
   assign rf_we     = rst_n & w_rf_we;
   assign alu_add   = rst_n & w_alu_add;
   assign imem_addr = w_imem_addr;
   assign dmem_addr = w_dmem_addr;
   assign rf_wsrc   = w_rf_wsrc;

   assign rf_wsel  = w_rd;
   assign rf_rsel1 = w_rs1;
   assign rf_rsel2 = (w_op == OP_ST && w_mode == MODE_ABS) ? w_rd : w_rs2;

   assign z_flag  = z_q;
   assign instret = instret_q;

endmodule
`default_nettype wire
